// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with selectable registered / first-word-fall-through read,
// almost-full/almost-empty thresholds, fill level, flush and sticky errors.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   flush, clr_err    : sync content clear, sticky error clear
//   wr_en, din        : write request and data
//   rd_en             : read / pop request
//   dout, valid       : read data and its qualifier
//   full, almost_full, empty, almost_empty, level : fill status
//   overflow, underflow : sticky rejected-write / rejected-read flags
module sync_fifo_v2 #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL  = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL  = LW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic             wr_rej;
  logic             rd_rej;

  assign empty        = (level == '0);
  assign full         = (level == LVL_MAX);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // flush masks both requests, so it neither moves data nor raises errors
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & (~full | rd_acc) & ~flush;
  assign wr_rej = wr_en & ~wr_acc & ~flush;
  assign rd_rej = rd_en & empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // a new error in the same cycle as clr_err keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_rej)       overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd_rej)       underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (flush) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end else begin : g_fwft
      assign dout  = mem[rd_ptr];
      assign valid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed self-checking bench for sync_fifo_v2.
// Registered-read instance (depth 4) plus a first-word-fall-through instance.
module tb_sync_fifo_v2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] din = '0;
  logic       rd_en = 1'b0;
  logic       full_a, af_a, valid_a, empty_a, ae_a, ovf_a, udf_a;
  logic [7:0] dout_a;
  logic [2:0] lvl_a;

  logic       wr_en2 = 1'b0;
  logic [7:0] din2 = '0;
  logic       rd_en2 = 1'b0;
  logic       full_b, af_b, valid_b, empty_b, ae_b, ovf_b, udf_b;
  logic [7:0] dout_b;
  logic [2:0] lvl_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_v2 #(
    .WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(2), .AE_THRESH(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .din(din), .full(full_a), .almost_full(af_a),
    .rd_en(rd_en), .dout(dout_a), .valid(valid_a), .empty(empty_a),
    .almost_empty(ae_a), .level(lvl_a), .overflow(ovf_a),
    .underflow(udf_a)
  );

  sync_fifo_v2 #(
    .WIDTH(8), .DEPTH(4), .FWFT(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en2), .din(din2), .full(full_b), .almost_full(af_b),
    .rd_en(rd_en2), .dout(dout_b), .valid(valid_b), .empty(empty_b),
    .almost_empty(ae_b), .level(lvl_b), .overflow(ovf_b),
    .underflow(udf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [7:0] rd_exp [4];

    // reset state
    #3;
    chk("rst_empty", empty_a, 1);
    chk("rst_ae", ae_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_af", af_a, 0);
    chk("rst_level", lvl_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_udf", udf_a, 0);
    chk("rst_b_empty", empty_b, 1);
    chk("rst_b_valid", valid_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fill to full
    wr(8'h11);
    chk("fill1_level", lvl_a, 1);
    chk("fill1_ae", ae_a, 1);
    chk("fill1_af", af_a, 0);
    wr(8'h22);
    chk("fill2_ae", ae_a, 0);
    chk("fill2_af", af_a, 1);
    wr(8'h33);
    wr(8'h44);
    chk("fill4_full", full_a, 1);
    chk("fill4_level", lvl_a, 4);
    chk("fill4_af", af_a, 1);

    // drain with back-to-back reads
    rd_exp[0] = 8'h11; rd_exp[1] = 8'h22;
    rd_exp[2] = 8'h33; rd_exp[3] = 8'h44;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_dout", dout_a, rd_exp[i]);
      chk("drain_valid", valid_a, 1);
      chk("drain_level", lvl_a, 3 - i);
    end
    rd_en = 1'b0;
    chk("drain_empty", empty_a, 1);
    tick();
    chk("idle_valid", valid_a, 0);
    chk("idle_dout_hold", dout_a, 8'h44);
    chk("drain_udf", udf_a, 0);

    // simultaneous read and write while full
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
    tick();
    wr_en = 1'b0;
    chk("rw_full_level", lvl_a, 4);
    chk("rw_full_ovf", ovf_a, 0);
    chk("rw_full_dout", dout_a, 8'h11);
    rd_exp[0] = 8'h22; rd_exp[1] = 8'h33;
    rd_exp[2] = 8'h44; rd_exp[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_drain_dout", dout_a, rd_exp[i]);
    end
    rd_en = 1'b0;
    tick();

    // overflow, sticky behaviour, clear, set-wins
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    wr(8'h99);
    chk("ovf_set", ovf_a, 1);
    chk("ovf_level", lvl_a, 4);
    tick();
    chk("ovf_sticky", ovf_a, 1);
    clr_err = 1'b1;
    tick();
    chk("ovf_clear", ovf_a, 0);
    wr_en = 1'b1; din = 8'h98;
    tick();
    wr_en = 1'b0;
    chk("ovf_set_wins", ovf_a, 1);
    tick();
    clr_err = 1'b0;
    chk("ovf_clear2", ovf_a, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ovf_drain_dout", dout_a, i + 1);
    end
    chk("ovf_drain_empty", empty_a, 1);

    // underflow on empty read
    tick();
    rd_en = 1'b0;
    chk("udf_set", udf_a, 1);
    chk("udf_dout", dout_a, 8'h04);
    chk("udf_valid", valid_a, 0);
    chk("udf_level", lvl_a, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("udf_clear", udf_a, 0);

    // pointer wrap: write/read pairs
    for (int i = 0; i < 10; i++) begin
      wr(8'hA0 + 8'(i));
      chk("wrap_wr_level", lvl_a, 1);
      chk("wrap_wr_ae", ae_a, 1);
      chk("wrap_wr_empty", empty_a, 0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("wrap_rd_dout", dout_a, 8'hA0 + i);
      chk("wrap_rd_valid", valid_a, 1);
      chk("wrap_rd_level", lvl_a, 0);
      chk("wrap_rd_ae", ae_a, 1);
    end

    // flush with concurrent write
    wr(8'h61); wr(8'h62); wr(8'h63);
    chk("pre_flush_level", lvl_a, 3);
    flush = 1'b1; wr_en = 1'b1; din = 8'hEE;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_level", lvl_a, 0);
    chk("flush_empty", empty_a, 1);
    chk("flush_valid", valid_a, 0);
    chk("flush_dout", dout_a, 0);
    chk("flush_ovf", ovf_a, 0);
    wr(8'h77);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_flush_dout", dout_a, 8'h77);

    // async reset mid-burst
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pre_rst_udf", udf_a, 1);
    wr(8'h31);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h32;
    tick();
    chk("pre_rst_valid", valid_a, 1);
    chk("pre_rst_dout", dout_a, 8'h31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", lvl_a, 0);
    chk("arst_empty", empty_a, 1);
    chk("arst_full", full_a, 0);
    chk("arst_valid", valid_a, 0);
    chk("arst_dout", dout_a, 0);
    chk("arst_udf", udf_a, 0);
    chk("arst_ovf", ovf_a, 0);
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // first-word-fall-through instance
    wr_en2 = 1'b1; din2 = 8'hA5;
    tick();
    wr_en2 = 1'b0;
    chk("fwft_dout", dout_b, 8'hA5);
    chk("fwft_valid", valid_b, 1);
    chk("fwft_empty", empty_b, 0);
    rd_en2 = 1'b1;
    tick();
    rd_en2 = 1'b0;
    chk("fwft_pop_empty", empty_b, 1);
    chk("fwft_pop_valid", valid_b, 0);
    wr_en2 = 1'b1; din2 = 8'hB1;
    tick();
    din2 = 8'hB2;
    tick();
    wr_en2 = 1'b0;
    chk("fwft_head_hold", dout_b, 8'hB1);
    chk("fwft_level2", lvl_b, 2);
    rd_en2 = 1'b1;
    tick();
    chk("fwft_next", dout_b, 8'hB2);
    chk("fwft_next_valid", valid_b, 1);
    tick();
    rd_en2 = 1'b0;
    chk("fwft_final_empty", empty_b, 1);
    chk("fwft_udf", udf_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
